// File: rtl/shift_register_ctrl_pkg.sv
// Shared types for the shift_register_ctrl sequencer.
package shift_register_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/shift_register.sv
// DEPTH x WIDTH delay line; all stages advance together when en is high.
module shift_register #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stages <= '{default: '0};
        end else if (en) begin
            r_stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign q = r_stages[DEPTH-1];

endmodule

// File: rtl/shift_register_ctrl.sv
// Flow-controlled sequencer around a shift_register delay line: valid/ready in and out,
// per-stage valid tracking, and flush/idle-timeout draining with bubbles.
module shift_register_ctrl
    import shift_register_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);

    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned CntW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    // A zero limit keeps the counter parked at 0 and the timeout compare disabled.
    localparam logic [CntW-1:0] CntMax = CntW'(IDLE_TIMEOUT);

    state_e            r_state;
    logic [DEPTH-1:0]  r_vbits;
    logic [CntW-1:0]   r_idle_cnt;
    logic              r_flush_done;

    logic              w_can_shift;
    logic              w_drain;
    logic              w_accept;
    logic              w_shift;
    logic              w_timeout;
    logic [DEPTH-1:0]  w_vbits_next;
    logic [WIDTH-1:0]  w_d;
    logic [LvlW-1:0]   w_level;

    assign w_can_shift  = !r_vbits[DEPTH-1] || m_ready;
    assign w_drain      = (r_state == ST_DRAIN);
    assign s_ready      = w_can_shift && !w_drain;
    assign w_accept     = s_valid && s_ready;
    assign w_shift      = w_accept || (w_drain && w_can_shift);
    assign w_timeout    = (IDLE_TIMEOUT != 0) && (r_idle_cnt == CntMax);
    assign w_vbits_next = w_shift ? {r_vbits[DEPTH-2:0], w_accept} : r_vbits;
    assign w_d          = w_accept ? s_data : '0;

    shift_register #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_shift_register (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_shift),
        .d     (w_d),
        .q     (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vbits      <= '0;
            r_idle_cnt   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_vbits      <= w_vbits_next;
            r_flush_done <= 1'b0;

            if (r_state != ST_FILL || w_accept) begin
                r_idle_cnt <= '0;
            end else if (!s_valid && r_idle_cnt != CntMax) begin
                r_idle_cnt <= r_idle_cnt + CntW'(1);
            end

            unique case (r_state)
                ST_IDLE: begin
                    // A word arriving with the flush is drained along with everything else.
                    if (w_accept) begin
                        r_state <= flush ? ST_DRAIN : ST_FILL;
                    end else if (flush) begin
                        r_flush_done <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_vbits_next == '0) begin
                        r_state      <= ST_IDLE;
                        r_flush_done <= flush;
                    end else if (flush || w_timeout) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_vbits_next == '0) begin
                        r_state      <= ST_IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_level = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_level = w_level + LvlW'(r_vbits[i]);
        end
    end

    assign m_valid    = r_vbits[DEPTH-1];
    assign level      = w_level;
    assign busy       = (r_state != ST_IDLE);
    assign flush_done = r_flush_done;

endmodule
